// File: rtl/banked_data_mem.sv
`default_nettype none
// banked_data_mem: byte-banked CPU/kernel data memory with a parameter/mask register window.
// Define MEM_FAULT_EN for strict mode (adds o_fault; faults misaligned, illegal-size, out-of-range accesses).
module banked_data_mem #(
   parameter int DATA_W      = 32,
   parameter int DEPTH_WORDS = 256,
   parameter int PARAM_BYTES = 8,
   parameter int MASK_BITS   = 25
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_cpu_valid,
   output logic                 o_cpu_ready,
   input  logic [31:0]          i_cpu_addr,
   input  logic [DATA_W-1:0]    i_cpu_wdata,
   input  logic [2:0]           i_cpu_func3,
   input  logic                 i_cpu_we,
   output logic                 o_cpu_rvalid,
   output logic [DATA_W-1:0]    o_cpu_rdata,
   input  logic                 i_krn_valid,
   input  logic [31:0]          i_krn_addr,
   input  logic [7:0]           i_krn_wdata,
   input  logic                 i_krn_we,
   output logic                 o_krn_rvalid,
   output logic [7:0]           o_krn_rdata,
   output logic [31:0]          o_parameters,
   output logic [MASK_BITS-1:0] o_mask
`ifdef MEM_FAULT_EN
   ,
   output logic                 o_fault
`endif
);
   localparam int LANES = DATA_W / 8;
   localparam int LB    = $clog2(LANES);
   localparam int DB    = $clog2(DEPTH_WORDS);
   localparam int PB    = (PARAM_BYTES > 1) ? $clog2(PARAM_BYTES) : 1;
   localparam int PW    = PB + 2;
   localparam logic [PW-1:0] P_LIM = PW'(PARAM_BYTES);

   logic                     krn, acc, cpu_acc, cpu_load, krn_load, we, is_param, sext;
   logic                     fault_now, do_write;
   logic [31:0]              addr, wdata, ld, ext;
   logic [2:0]               nbytes;
   logic [LB-1:0]            off;
   logic [DB-1:0]            base_row;
   logic [PB-1:0]            poff;
   logic [8*PARAM_BYTES-1:0] prm_flat;
   logic [DATA_W-1:0]        lane_rd;
   logic                     unused_bits;

   // Kernel always wins; the CPU is simply told it was not accepted.
   assign krn         = i_krn_valid;
   assign o_cpu_ready = ~i_krn_valid;
   assign acc         = ~rst & (i_krn_valid | i_cpu_valid);
   assign cpu_acc     = ~rst & ~i_krn_valid & i_cpu_valid;
   assign cpu_load    = cpu_acc & ~i_cpu_we;
   assign krn_load    = ~rst & i_krn_valid & ~i_krn_we;
   assign addr        = krn ? i_krn_addr : i_cpu_addr;
   assign we          = krn ? i_krn_we : i_cpu_we;
   assign wdata       = krn ? {24'd0, i_krn_wdata} : i_cpu_wdata[31:0];
   assign sext        = ~krn & ~i_cpu_func3[2];
   assign is_param    = addr[31];
   assign off         = addr[LB-1:0];
   assign base_row    = addr[LB +: DB];
   assign poff        = addr[PB-1:0];
   assign unused_bits = ^{addr[30:0], prm_flat};

   always_comb begin
      nbytes = 3'd4;
      if (krn)                         nbytes = 3'd1;
      else if (i_cpu_func3[1:0] == 2'b00) nbytes = 3'd1;
      else if (i_cpu_func3[1:0] == 2'b01) nbytes = 3'd2;
   end

`ifdef MEM_FAULT_EN
   localparam logic [31:0] DATA_BYTES = 32'(DEPTH_WORDS * LANES);
   logic illegal, misal, oob;
   assign illegal   = (i_cpu_func3 == 3'b011) | (i_cpu_func3[2:1] == 2'b11);
   assign misal     = ((i_cpu_func3[1:0] == 2'b01) & addr[0]) |
                      ((i_cpu_func3 == 3'b010) & (addr[1:0] != 2'b00));
   assign oob       = ~addr[31] & (addr >= DATA_BYTES);
   assign fault_now = cpu_acc & (illegal | misal | oob);
`else
   assign fault_now = 1'b0;
`endif

   assign do_write = acc & we & ~fault_now;

   generate
      // Lane l carries access byte k = (l - off) mod LANES; lanes below off sit in the next row.
      for (genvar l = 0; l < LANES; l++) begin : g_lane
         logic [7:0]    mem [DEPTH_WORDS];
         logic [LB-1:0] k;
         logic [DB-1:0] row;
         logic          hit;
         assign k   = LB'(l) - off;
         assign row = base_row + DB'(LB'(l) < off);
         assign hit = 32'(k) < 32'(nbytes);
         always_ff @(posedge clk) begin
            if (do_write & ~is_param & hit)
               mem[row] <= wdata[{k[1:0], 3'b000} +: 8];
         end
         assign lane_rd[8*l +: 8] = mem[row];
      end

      for (genvar b = 0; b < 4; b++) begin : g_byte
         logic [LB-1:0]            ln;
         logic [PW-1:0]            pidx;
         logic [8*PARAM_BYTES-1:0] psh;
         assign ln   = off + LB'(b);
         assign pidx = PW'(poff) + PW'(b);
         assign psh  = prm_flat >> {pidx, 3'b000};
         assign ld[8*b +: 8] = is_param ? ((pidx < P_LIM) ? psh[7:0] : 8'd0)
                                        : lane_rd[{ln, 3'b000} +: 8];
      end

      // Bytes falling past the end of the window are silently dropped.
      for (genvar p = 0; p < PARAM_BYTES; p++) begin : g_prm
         logic [7:0]    r;
         logic [PW-1:0] dk;
         logic          hit;
         assign dk  = PW'(p) - PW'(poff);
         assign hit = (PW'(p) >= PW'(poff)) && (32'(dk) < 32'(nbytes));
         always_ff @(posedge clk) begin
            if (rst)
               r <= 8'd0;
            else if (do_write & is_param & hit)
               r <= wdata[{dk[1:0], 3'b000} +: 8];
         end
         assign prm_flat[8*p +: 8] = r;
      end
   endgenerate

   assign o_parameters = prm_flat[31:0];
   assign o_mask       = prm_flat[32 +: MASK_BITS];

   always_comb begin
      ext = ld;
      if (nbytes == 3'd1)      ext = {{24{sext & ld[7]}}, ld[7:0]};
      else if (nbytes == 3'd2) ext = {{16{sext & ld[15]}}, ld[15:0]};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         o_cpu_rvalid <= 1'b0;
         o_cpu_rdata  <= '0;
         o_krn_rvalid <= 1'b0;
         o_krn_rdata  <= 8'd0;
`ifdef MEM_FAULT_EN
         o_fault      <= 1'b0;
`endif
      end else begin
         o_cpu_rvalid <= cpu_load;
         o_krn_rvalid <= krn_load;
         if (cpu_load) o_cpu_rdata <= fault_now ? '0 : DATA_W'(ext);
         if (krn_load) o_krn_rdata <= ld[7:0];
`ifdef MEM_FAULT_EN
         o_fault      <= fault_now;
`endif
      end
   end
endmodule
`default_nettype wire
